// File: rtl/msx_slot.sv
// MSX cartridge slot to internal bus bridge: one request per MSX I/O or memory access, read data driven back on the slot.
// Latency: bus_valid 3 clocks after strobes settle (2-flop sync + state register); MSX held with /WAIT until read data returns.
module msx_slot (
  input  logic        clk42m,
  input  logic        reset,
  input  logic        initial_busy,
  input  logic        p_slot_reset_n,
  input  logic        p_slot_sltsl_n,
  input  logic        p_slot_mreq_n,
  input  logic        p_slot_ioreq_n,
  input  logic        p_slot_wr_n,
  input  logic        p_slot_rd_n,
  input  logic [15:0] p_slot_address,
  inout  wire  [7:0]  p_slot_data,
  output logic        p_slot_data_dir,
  output logic        p_slot_int,
  output logic        p_slot_wait,
  input  logic        int_n,
  output logic        bus_memreq,
  output logic        bus_ioreq,
  output logic [15:0] bus_address,
  output logic        bus_write,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_rdata_en
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

  // Strobe bit order: {reset_n, sltsl_n, mreq_n, ioreq_n, wr_n, rd_n}
  logic [5:0]  strb_s1_q, strb_s2_q;
  logic [15:0] addr_s1_q, addr_s2_q;
  logic [7:0]  dat_s1_q, dat_s2_q;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        write_q, write_d;
  logic        memreq_q, memreq_d;
  logic        ioreq_q, ioreq_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        dir_q, dir_d;
  logic        wait_q, wait_d;
  logic        int_q, int_d;

  logic rst_n_s, sltsl_s, mreq_s, ioreq_s, wr_s, rd_s;
  logic rw_acc, io_acc, mem_acc, any_acc, bus_idle;

  assign {rst_n_s, sltsl_s, mreq_s, ioreq_s, wr_s, rd_s} = strb_s2_q;

  always_comb begin
    rw_acc   = ~wr_s | ~rd_s;
    io_acc   = ~ioreq_s & rw_acc;
    mem_acc  = ~sltsl_s & ~mreq_s & rw_acc;
    any_acc  = io_acc | mem_acc;
    bus_idle = ioreq_s & mreq_s & rd_s & wr_s;

    state_d  = state_q;
    valid_d  = valid_q;
    write_d  = write_q;
    memreq_d = memreq_q;
    ioreq_d  = ioreq_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    dir_d    = dir_q;
    int_d    = ~int_n;

    case (state_q)
      IDLE: begin
        // Request is held off while downstream initialises; /WAIT stretches the MSX cycle meanwhile.
        if (any_acc && !initial_busy) begin
          state_d  = REQ;
          valid_d  = 1'b1;
          write_d  = ~wr_s;
          ioreq_d  = io_acc;
          memreq_d = ~io_acc;
          addr_d   = addr_s2_q;
          wdata_d  = dat_s2_q;
        end
      end
      REQ: begin
        if (bus_ready) begin
          valid_d = 1'b0;
          state_d = write_q ? DONE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (bus_rdata_en) begin
          rdata_d = bus_rdata;
          dir_d   = ~rd_s;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rd_s) dir_d = 1'b0;

    wait_d = (((state_d == REQ) || (state_d == WAIT_RD)) && !write_d) || (initial_busy && any_acc);

    // Slot /RESET behaves like reset for everything except the interrupt line.
    if (!rst_n_s) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      write_d  = 1'b0;
      memreq_d = 1'b0;
      ioreq_d  = 1'b0;
      addr_d   = '0;
      wdata_d  = '0;
      dir_d    = 1'b0;
      wait_d   = 1'b0;
    end
  end

  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      strb_s1_q <= '1;
      strb_s2_q <= '1;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      dat_s1_q  <= '0;
      dat_s2_q  <= '0;
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      memreq_q  <= 1'b0;
      ioreq_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      dir_q     <= 1'b0;
      wait_q    <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      strb_s1_q <= {p_slot_reset_n, p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n, p_slot_wr_n, p_slot_rd_n};
      strb_s2_q <= strb_s1_q;
      addr_s1_q <= p_slot_address;
      addr_s2_q <= addr_s1_q;
      dat_s1_q  <= p_slot_data;
      dat_s2_q  <= dat_s1_q;
      state_q   <= state_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      memreq_q  <= memreq_d;
      ioreq_q   <= ioreq_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      dir_q     <= dir_d;
      wait_q    <= wait_d;
      int_q     <= int_d;
    end
  end

  assign p_slot_data     = dir_q ? rdata_q : 8'hzz;
  assign p_slot_data_dir = dir_q;
  assign p_slot_int      = int_q;
  assign p_slot_wait     = wait_q;
  assign bus_valid       = valid_q;
  assign bus_write       = write_q;
  assign bus_memreq      = memreq_q;
  assign bus_ioreq       = ioreq_q;
  assign bus_address     = addr_q;
  assign bus_wdata       = wdata_q;

endmodule

// File: tb/tb_msx_slot.sv
// Scoreboard bench for msx_slot: MSX-side stimulus pushes expected requests, a monitor checks each bus_valid pulse.
`timescale 1ns/1ps
module tb_msx_slot;

  logic        clk = 1'b0;
  logic        reset;
  logic        initial_busy;
  logic        p_rst_n, p_sltsl_n, p_mreq_n, p_ioreq_n, p_wr_n, p_rd_n;
  logic [15:0] p_addr;
  wire  [7:0]  p_slot_data;
  logic [7:0]  tb_drv;
  logic        tb_oe;
  logic        p_slot_data_dir, p_slot_int, p_slot_wait;
  logic        int_n;
  logic        bus_memreq, bus_ioreq, bus_write, bus_valid;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        rsp_ready, rsp_en, poke_ready, poke_en;

  assign p_slot_data = tb_oe ? tb_drv : 8'hzz;

  always #11.64 clk = ~clk;

  msx_slot dut (
    .clk42m(clk), .reset(reset), .initial_busy(initial_busy),
    .p_slot_reset_n(p_rst_n), .p_slot_sltsl_n(p_sltsl_n), .p_slot_mreq_n(p_mreq_n),
    .p_slot_ioreq_n(p_ioreq_n), .p_slot_wr_n(p_wr_n), .p_slot_rd_n(p_rd_n),
    .p_slot_address(p_addr), .p_slot_data(p_slot_data),
    .p_slot_data_dir(p_slot_data_dir), .p_slot_int(p_slot_int), .p_slot_wait(p_slot_wait),
    .int_n(int_n), .bus_memreq(bus_memreq), .bus_ioreq(bus_ioreq),
    .bus_address(bus_address), .bus_write(bus_write), .bus_valid(bus_valid),
    .bus_ready(rsp_ready | poke_ready), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_en(rsp_en | poke_en)
  );

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic        io;
    logic [7:0]  d;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   errs = 0;
  int   checks = 0;
  int   n_pulses = 0;
  int   n_expected = 0;
  int   resp_dly = 0;
  logic resp_hold = 1'b0;
  logic [7:0] rd_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic w, input logic io, input logic [7:0] d);
    exp_t e;
    e.a = a; e.w = w; e.io = io; e.d = d;
    exp_q.push_back(e);
    n_expected++;
  endtask

  // Monitor: pops one expectation per bus_valid rising edge and checks the fields stay stable.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_valid && !prev) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {bus_ioreq, bus_memreq, bus_address}, 32'hffffffff);
        end else begin
          cur = exp_q.pop_front();
          chk("req_addr", bus_address, cur.a);
          chk("req_write", bus_write, cur.w);
          chk("req_ioreq", bus_ioreq, cur.io);
          chk("req_memreq", bus_memreq, !cur.io);
          if (cur.w) chk("req_wdata", bus_wdata, cur.d);
        end
      end else if (bus_valid && prev) begin
        chk("req_addr_stable", bus_address, cur.a);
        if (cur.w) chk("req_wdata_stable", bus_wdata, cur.d);
      end
      prev = bus_valid;
    end
  end

  // Bus-side responder: ready after resp_dly clocks for one clock, read data two clocks later.
  initial begin
    logic is_rd;
    rsp_ready = 1'b0; rsp_en = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_valid && !resp_hold) begin
        is_rd = !bus_write;
        repeat (resp_dly) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("valid_drop_on_ready", bus_valid, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (is_rd) begin
          repeat (2) @(negedge clk);
          bus_rdata = rd_val;
          rsp_en = 1'b1;
          @(negedge clk);
          rsp_en = 1'b0;
        end
      end
    end
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  task automatic strobes_on(input logic is_io, input logic is_wr, input logic [15:0] a,
                            input logic [7:0] d, input int d_rw, input int d_stb);
    p_addr = a;
    tb_drv = d;
    tb_oe  = is_wr;
    #(d_rw);
    if (is_wr) p_wr_n = 1'b0; else p_rd_n = 1'b0;
    #(d_stb - d_rw);
    if (is_io) p_ioreq_n = 1'b0;
    else begin p_mreq_n = 1'b0; p_sltsl_n = 1'b0; end
  endtask

  task automatic strobes_off();
    p_ioreq_n = 1'b1; p_mreq_n = 1'b1; p_sltsl_n = 1'b1;
    p_wr_n = 1'b1; p_rd_n = 1'b1;
    #20;
    tb_oe = 1'b0;
    #300;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int d_rw, input int d_stb);
    push_exp(a, 1'b1, 1'b1, d);
    strobes_on(1'b1, 1'b1, a, d, d_rw, d_stb);
    #840;
    strobes_off();
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12 && !bus_valid; i++) @(negedge clk);
    chk(name, bus_valid, 1'b1);
  endtask

  initial begin
    logic [15:0] wa [5];
    logic [7:0]  wd [5];
    wa = '{16'h0089, 16'h0078, 16'h0067, 16'h0056, 16'h0045};
    wd = '{8'h23, 8'h34, 8'h45, 8'h56, 8'h67};

    reset = 1'b1; initial_busy = 1'b0; int_n = 1'b0;
    p_rst_n = 1'b1; p_sltsl_n = 1'b1; p_mreq_n = 1'b1; p_ioreq_n = 1'b1;
    p_wr_n = 1'b1; p_rd_n = 1'b1; p_addr = 16'h0000; tb_drv = 8'h00; tb_oe = 1'b0;
    poke_ready = 1'b0; poke_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_write", bus_write, 1'b0);
    chk("rst_memreq", bus_memreq, 1'b0);
    chk("rst_ioreq", bus_ioreq, 1'b0);
    chk("rst_addr", bus_address, 16'h0000);
    chk("rst_wdata", bus_wdata, 8'h00);
    chk("rst_dir", p_slot_data_dir, 1'b0);
    chk("rst_wait", p_slot_wait, 1'b0);
    chk("rst_int", p_slot_int, 1'b0);
    int_n = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single I/O write, ready answered immediately.
    resp_dly = 0;
    io_write(16'h0098, 8'h12, 125, 135);

    // Back-to-back writes with late strobes and slow ready.
    resp_dly = 3;
    for (int i = 0; i < 5; i++) io_write(wa[i], wd[i], 165, 175);
    chk("b2b_pulses", n_pulses, 6);

    // Memory read returning 0xA5 onto the slot data bus.
    rd_val = 8'hA5;
    push_exp(16'h4000, 1'b0, 1'b0, 8'h00);
    strobes_on(1'b0, 1'b0, 16'h4000, 8'h00, 125, 135);
    wait_valid("rd_valid_seen");
    chk("rd_wait_in_req", p_slot_wait, 1'b1);
    for (int i = 0; i < 40 && !p_slot_data_dir; i++) @(negedge clk);
    chk("rd_dir_on", p_slot_data_dir, 1'b1);
    chk("rd_wait_released", p_slot_wait, 1'b0);
    chk("rd_data", p_slot_data, 8'hA5);
    #200;
    chk("rd_dir_held", p_slot_data_dir, 1'b1);
    chk("rd_data_held", p_slot_data, 8'hA5);
    strobes_off();
    chk("rd_dir_off", p_slot_data_dir, 1'b0);
    chk("rd_data_z", (p_slot_data === 8'hzz), 1'b1);

    // /MREQ without /SLTSL must be ignored.
    p_addr = 16'h8000; p_rd_n = 1'b0; #10 p_mreq_n = 1'b0;
    #840;
    strobes_off();
    chk("no_sltsl_pulses", n_pulses, 7);

    // Stray ready/rdata_en in IDLE change nothing.
    @(negedge clk); poke_ready = 1'b1; poke_en = 1'b1;
    repeat (3) @(negedge clk); poke_ready = 1'b0; poke_en = 1'b0;
    @(negedge clk);
    chk("idle_ready_valid", bus_valid, 1'b0);
    chk("idle_en_dir", p_slot_data_dir, 1'b0);

    // Interrupt pass-through.
    @(negedge clk); int_n = 1'b0;
    @(posedge clk); #1;
    chk("int_assert", p_slot_int, 1'b1);
    @(negedge clk); int_n = 1'b1;
    @(posedge clk); #1;
    chk("int_release", p_slot_int, 1'b0);

    // initial_busy holds the request and asserts /WAIT until cleared.
    resp_dly = 1;
    initial_busy = 1'b1;
    strobes_on(1'b1, 1'b1, 16'h00A0, 8'h77, 125, 135);
    repeat (6) @(negedge clk);
    chk("busy_wait", p_slot_wait, 1'b1);
    chk("busy_no_valid", bus_valid, 1'b0);
    push_exp(16'h00A0, 1'b1, 1'b1, 8'h77);
    initial_busy = 1'b0;
    wait_valid("busy_then_valid");
    #600;
    strobes_off();

    // Reset during REQ aborts the request at once.
    resp_hold = 1'b1;
    push_exp(16'h0011, 1'b1, 1'b1, 8'h99);
    strobes_on(1'b1, 1'b1, 16'h0011, 8'h99, 125, 135);
    wait_valid("abort_valid_seen");
    reset = 1'b1;
    #1;
    chk("abort_valid_low", bus_valid, 1'b0);
    chk("abort_addr_clr", bus_address, 16'h0000);
    strobes_off();
    @(negedge clk); reset = 1'b0;
    resp_hold = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_retry", bus_valid, 1'b0);

    // Slot /RESET blocks accesses but keeps the interrupt line live.
    p_rst_n = 1'b0; int_n = 1'b0;
    strobes_on(1'b1, 1'b1, 16'h0022, 8'h55, 125, 135);
    #840;
    chk("slot_rst_int", p_slot_int, 1'b1);
    chk("slot_rst_valid", bus_valid, 1'b0);
    strobes_off();
    p_rst_n = 1'b1; int_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("pulse_total", n_pulses, n_expected);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/msx_slot.md
MSX_SLOT -- requirements
Module: msx_slot

Interface
REQ-001 clk42m  in  1  system clock, 42.95454 MHz; all logic on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 initial_busy  in  1  high while downstream is still initialising.
REQ-004 p_slot_reset_n  in  1  MSX slot /RESET.
REQ-005 p_slot_sltsl_n, p_slot_mreq_n, p_slot_ioreq_n, p_slot_wr_n, p_slot_rd_n  in  1 each  MSX bus strobes, active-low, asynchronous to clk42m.
REQ-006 p_slot_address  in  16  MSX address bus.
REQ-007 p_slot_data  inout  8  MSX data bus.
REQ-008 p_slot_data_dir  out  1  data buffer direction: 1 = module drives p_slot_data; 0 = MSX drives.
REQ-009 p_slot_int  out  1  1 = pull MSX /INT low.
REQ-010 p_slot_wait  out  1  1 = pull MSX /WAIT low.
REQ-011 int_n  in  1  internal interrupt request, active-low.
REQ-012 bus_memreq, bus_ioreq  out  1 each  transaction type flags.
REQ-013 bus_address  out  16  transaction address.
REQ-014 bus_write  out  1  1 = write, 0 = read.
REQ-015 bus_valid  out  1  request strobe.
REQ-016 bus_ready  in  1  request accepted.
REQ-017 bus_wdata  out  8  write data.
REQ-018 bus_rdata  in  8  read data.
REQ-019 bus_rdata_en  in  1  bus_rdata is valid this cycle.

Function
REQ-020 Strobes and address/data inputs SHALL pass a 2-flop synchroniser before use.
REQ-021 An I/O access SHALL be detected when synchronised /IORQ is low and /WR or /RD is low; the full 16-bit address is forwarded with no decoding.
REQ-022 A memory access SHALL be detected when /SLTSL, /MREQ and either /WR or /RD are low.
REQ-023 State machine: IDLE -> REQ when an access is detected; REQ -> WAIT_RD on the cycle bus_ready=1 for a read; REQ -> DONE on the cycle bus_ready=1 for a write; WAIT_RD -> DONE on bus_rdata_en=1; DONE -> IDLE once /IORQ, /MREQ, /RD and /WR are all high.
REQ-024 On entry to REQ, the module SHALL latch bus_address, bus_write, bus_ioreq/bus_memreq (exactly one high) and bus_wdata (synchronised p_slot_data), and hold them stable through REQ.
REQ-025 bus_valid SHALL be 1 only in REQ.
REQ-026 bus_valid SHALL rise within 4 clk42m cycles of the later of strobe-low and /WR-or-/RD-low.
REQ-027 bus_valid SHALL fall on the clock edge that samples bus_ready=1.
REQ-028 Exactly one bus request SHALL be issued per MSX access, regardless of strobe length.
REQ-029 Read data SHALL be latched on bus_rdata_en.
REQ-030 p_slot_data_dir=1 and p_slot_data driven with the latched read data from capture until /RD rises; otherwise p_slot_data_dir=0 and p_slot_data=Z.
REQ-031 p_slot_wait=1 during REQ or WAIT_RD of a read, or while initial_busy=1 and an access is detected; otherwise 0.
REQ-032 p_slot_int SHALL be the registered value of ~int_n.
REQ-033 p_slot_reset_n low (synchronised) SHALL force IDLE like reset, except p_slot_int remains active.
REQ-034 bus_ready in IDLE or DONE and bus_rdata_en outside WAIT_RD SHALL be ignored.

Reset
REQ-035 While reset=1: state IDLE; bus_valid, bus_write, bus_memreq, bus_ioreq, p_slot_data_dir, p_slot_wait, p_slot_int = 0; bus_address = 0; bus_wdata = 0; synchronisers read as strobes inactive (high).
REQ-036 Reset asserted mid-transaction SHALL abort it with no further bus_valid.

Verification
REQ-037 I/O write 0x98 <- 0x12, Z80 timing with 1 wait state, /IORQ 135 ns and /WR 125 ns after T2 rise -> single bus_valid pulse; while valid: bus_address=0x0098, bus_write=1, bus_ioreq=1, bus_wdata=0x12; bus_ready held 1 clock -> bus_valid=0 on the next edge.
REQ-038 Back-to-back I/O writes 0x89/0x23, 0x78/0x34, 0x67/0x45, 0x56/0x56, 0x45/0x67, with late strobes (175/165 ns) and ready delayed 3 clocks -> one request each, correct address/data, bus_valid low between accesses.
REQ-039 Memory read 0x4000 with /SLTSL low, bus_rdata=0xA5 with bus_rdata_en -> p_slot_wait high until capture, then p_slot_data_dir=1 and p_slot_data=0xA5 until /RD rises.
REQ-040 /MREQ access with /SLTSL high -> no bus_valid.
REQ-041 int_n=0 -> p_slot_int=1 within 1 clock; reset asserted during REQ -> bus_valid=0 immediately.
